if_prefetch: RTL

- Parametrised instruction-fetch unit that replaces the single-register PC stage of the core.
- Issues pipelined requests to instruction memory using a req/gnt/rvalid handshake, with up to DEPTH requests outstanding.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and hands them to decode over a valid/ready interface.
- On a taken branch/jump from ID it flushes the FIFO, discards in-flight responses and redirects fetch.

---
 rtl/if_prefetch_if.sv | 19 +
 rtl/if_prefetch.sv | 104 ++++++++++
 2 files changed

// File: rtl/if_prefetch_if.sv
// if_prefetch_if: req/gnt/rvalid instruction-memory bus between the fetch unit (master) and memory (slave)
interface if_prefetch_if #(
  parameter int XLEN = 32
);
  logic            inst_ce_o;
  logic            inst_req_o;
  logic [XLEN-1:0] inst_addr_o;
  logic            inst_gnt_i;
  logic            inst_rvalid_i;
  logic [31:0]     inst_i;
  modport master (
    output inst_ce_o, inst_req_o, inst_addr_o,
    input  inst_gnt_i, inst_rvalid_i, inst_i
  );
  modport slave (
    input  inst_ce_o, inst_req_o, inst_addr_o,
    output inst_gnt_i, inst_rvalid_i, inst_i
  );
endinterface

// File: rtl/if_prefetch.sv
// if_prefetch: pipelined instruction prefetch with DEPTH-entry FIFO and branch flush; IF_PREFETCH_PERF_EN adds bubble/flush counters
module if_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_i,
  input  logic [XLEN-1:0]  branch_addr_i,
  if_prefetch_if.master    mem,
  output logic             id_valid_o,
  input  logic             id_ready_i,
  output logic [31:0]      id_inst_o,
  output logic [XLEN-1:0]  id_pc_o
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]      perf_bubble_o,
  output logic [31:0]      perf_flush_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;
  localparam logic [CW-1:0] DEP = CW'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d, tgt;
  logic [CW-1:0]   count_q, count_d, os_q, os_d, dis_q, dis_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic            ce_q, req, fire, drop, push, pop;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0]     inst_mem [DEPTH];

  assign id_valid_o      = count_q != '0;
  assign id_inst_o       = id_valid_o ? inst_mem[rd_q] : '0;
  assign id_pc_o         = id_valid_o ? pc_mem[rd_q] : '0;
  assign mem.inst_ce_o   = ce_q;
  assign mem.inst_req_o  = req;
  assign mem.inst_addr_o = pc_q;

  // credit check, handshake events and next state; a branch overrides every other event
  always_comb begin
    tgt       = branch_addr_i & ~XLEN'(3);
    req       = rst && ce_q && !branch_i && (count_q + os_q < DEP) && (os_q + dis_q < DEP);
    fire      = req && mem.inst_gnt_i;
    drop      = mem.inst_rvalid_i && (dis_q != '0);
    push      = mem.inst_rvalid_i && (dis_q == '0) && !branch_i;
    pop       = id_valid_o && id_ready_i && !branch_i;
    pc_d      = branch_i ? tgt : fire ? pc_q + XLEN'(4) : pc_q;
    resp_pc_d = branch_i ? tgt : push ? resp_pc_q + XLEN'(4) : resp_pc_q;
    os_d      = branch_i ? '0 : os_q + CW'(fire) - CW'(push);
    dis_d     = branch_i ? dis_q + os_q - CW'(mem.inst_rvalid_i) : dis_q - CW'(drop);
    count_d   = branch_i ? '0 : count_q + CW'(push) - CW'(pop);
    wr_d      = branch_i ? '0 : wr_q + AW'(push);
    rd_d      = branch_i ? '0 : rd_q + AW'(pop);
  end

  // control state; chip select rises on the first edge out of reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      count_q   <= '0;
      os_q      <= '0;
      dis_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      ce_q      <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      count_q   <= count_d;
      os_q      <= os_d;
      dis_q     <= dis_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      ce_q      <= 1'b1;
    end
  end

  // FIFO storage; contents are only meaningful below count_q so it needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]   <= resp_pc_q;
      inst_mem[wr_q] <= mem.inst_i;
    end
  end

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] bubble_q, flush_q;
  assign perf_bubble_o = bubble_q;
  assign perf_flush_o  = flush_q;

  // free-running counters of decode starvation cycles and redirects
  always_ff @(posedge clk) begin
    if (!rst) begin
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      bubble_q <= bubble_q + 32'(ce_q && id_ready_i && !id_valid_o);
      flush_q  <= flush_q + 32'(branch_i);
    end
  end
`endif
endmodule
